// File: rtl/jtag_scan_master.sv
// jtag_scan_master: virtual-JTAG initiator that runs IR/DR scans and returns captured TDO bits.
// Optional macro JTAG_SCAN_MASTER_RTI_WAIT_EN adds rti_wait_i extra RTI periods before the response.
module jtag_scan_master #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned MAX_LEN = 38,
    parameter int unsigned LEN_W   = 6
) (
    input  logic               clk_i,
    input  logic               reset_i,
`ifdef JTAG_SCAN_MASTER_RTI_WAIT_EN
    input  logic [7:0]         rti_wait_i,
`endif
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_is_ir_i,
    input  logic [LEN_W-1:0]   cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_data_i,
    output logic               rsp_valid_o,
    output logic [MAX_LEN-1:0] rsp_data_o,
    output logic               busy_o,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    input  logic               tdo_i
);
    localparam int unsigned      DIV_W    = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    typedef enum logic [3:0] {
        ST_INIT, ST_IDLE, ST_START, ST_HDR, ST_SHIFT, ST_TAIL, ST_RWAIT, ST_RESP, ST_DONE
    } state_e;

    state_e             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [2:0]         step_q;
    logic [LEN_W-1:0]   bit_q;
    logic [LEN_W-1:0]   len_q;
    logic               is_ir_q;
    logic [MAX_LEN-1:0] data_q;
    logic [MAX_LEN-1:0] rsp_q;
    logic               tck_q;
    logic               tms_q;
    logic               tdi_q;
    logic               ready_q;
    logic               rsp_valid_q;
    logic               busy_q;
`ifdef JTAG_SCAN_MASTER_RTI_WAIT_EN
    logic [7:0]         wait_q;
    logic               wait_req_c;
`endif

    logic [LEN_W-1:0]   eff_len_c;
    logic               div_end_c;
    logic [2:0]         step_nxt_c;
    logic [LEN_W-1:0]   bit_nxt_c;
    logic               hdr_last_c;
    logic               finish_c;

    // Per-cycle decode: clamped length, divider wrap, and whether the current TCK period ends the scan.
    always_comb begin
        eff_len_c  = (cmd_len_i > LEN_MAX) ? LEN_MAX : cmd_len_i;
        div_end_c  = (div_q == DIV_LAST);
        step_nxt_c = step_q + 3'd1;
        bit_nxt_c  = bit_q + LEN_W'(1);
        hdr_last_c = (step_q == (is_ir_q ? 3'd3 : 3'd2));
`ifdef JTAG_SCAN_MASTER_RTI_WAIT_EN
        wait_req_c = (rti_wait_i != 8'd0);
        finish_c   = ((state_q == ST_TAIL) && (step_q == 3'd1) && !wait_req_c) ||
                     ((state_q == ST_RWAIT) && (wait_q == 8'd0));
`else
        finish_c   = (state_q == ST_TAIL) && (step_q == 3'd1);
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_INIT;
            div_q       <= '0;
            step_q      <= '0;
            bit_q       <= '0;
            len_q       <= '0;
            is_ir_q     <= 1'b0;
            data_q      <= '0;
            rsp_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef JTAG_SCAN_MASTER_RTI_WAIT_EN
            wait_q      <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i && ready_q) begin
                        is_ir_q <= cmd_is_ir_i;
                        len_q   <= eff_len_c;
                        data_q  <= cmd_data_i;
                        rsp_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    div_q  <= '0;
                    step_q <= '0;
                    tdi_q  <= 1'b0;
                    if (len_q == '0) begin
                        state_q <= ST_RESP;
                    end else begin
                        tms_q   <= 1'b1;
                        state_q <= ST_HDR;
                    end
                end
                ST_RESP: begin
                    rsp_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    // TCK-generating states: tms/tdi move on the falling edge, tdo is sampled on the rising edge.
                    if (!div_end_c) begin
                        div_q <= div_q + DIV_W'(1);
                    end else begin
                        div_q <= '0;
                        if (!tck_q) begin
                            tck_q <= 1'b1;
                            if (state_q == ST_SHIFT) rsp_q[bit_q] <= tdo_i;
                        end else begin
                            tck_q <= 1'b0;
                            if (finish_c) begin
                                tms_q       <= 1'b0;
                                tdi_q       <= 1'b0;
                                rsp_valid_q <= 1'b1;
                                busy_q      <= 1'b0;
                                state_q     <= ST_DONE;
                            end else begin
                                case (state_q)
                                    ST_INIT: begin
                                        if (step_q == 3'd5) begin
                                            tms_q   <= 1'b0;
                                            ready_q <= 1'b1;
                                            state_q <= ST_IDLE;
                                        end else begin
                                            step_q <= step_nxt_c;
                                            tms_q  <= (step_nxt_c != 3'd5);
                                        end
                                    end
                                    ST_HDR: begin
                                        if (hdr_last_c) begin
                                            bit_q   <= '0;
                                            tdi_q   <= data_q[0];
                                            tms_q   <= (len_q == LEN_W'(1));
                                            state_q <= ST_SHIFT;
                                        end else begin
                                            step_q <= step_nxt_c;
                                            tms_q  <= is_ir_q && (step_nxt_c == 3'd1);
                                        end
                                    end
                                    ST_SHIFT: begin
                                        if (bit_nxt_c == len_q) begin
                                            step_q  <= '0;
                                            tms_q   <= 1'b1;
                                            tdi_q   <= 1'b0;
                                            state_q <= ST_TAIL;
                                        end else begin
                                            bit_q  <= bit_nxt_c;
                                            data_q <= data_q >> 1;
                                            tdi_q  <= data_q[1];
                                            tms_q  <= (bit_nxt_c == len_q - LEN_W'(1));
                                        end
                                    end
                                    ST_TAIL: begin
                                        if (step_q == 3'd0) begin
                                            step_q <= 3'd1;
                                            tms_q  <= 1'b0;
                                        end
`ifdef JTAG_SCAN_MASTER_RTI_WAIT_EN
                                        else begin
                                            wait_q  <= rti_wait_i - 8'd1;
                                            tms_q   <= 1'b0;
                                            state_q <= ST_RWAIT;
                                        end
`else
`endif
                                    end
`ifdef JTAG_SCAN_MASTER_RTI_WAIT_EN
                                    ST_RWAIT: wait_q <= wait_q - 8'd1;
`else
`endif
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign cmd_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_q;
    assign busy_o      = busy_q;
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Scoreboard bench for jtag_scan_master: TDO is either looped from TDI through a TCK-rise flop or tied high.
module tb_jtag_scan_master;
    localparam int unsigned MAX_LEN = 38;
    localparam int unsigned LEN_W   = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_is_ir;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               busy;
    logic               tck;
    logic               tms;
    logic               tdi;
    logic               tdo;
`ifdef JTAG_SCAN_MASTER_RTI_WAIT_EN
    logic [7:0]         rti_wait;
`endif

    logic               tdo_tied;
    logic               loop_q = 1'b0;
    int                 rti_w;
    int                 checks = 0;
    int                 errors = 0;
    int                 rsp_pulses = 0;
    logic               tms_log[$];
    logic               tdi_log[$];
    logic [MAX_LEN-1:0] exp_q[$];

    jtag_scan_master #(.CLK_DIV(2), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk_i       (clk),
        .reset_i     (rst),
`ifdef JTAG_SCAN_MASTER_RTI_WAIT_EN
        .rti_wait_i  (rti_wait),
`endif
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_is_ir_i (cmd_is_ir),
        .cmd_len_i   (cmd_len),
        .cmd_data_i  (cmd_data),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .busy_o      (busy),
        .tck_o       (tck),
        .tms_o       (tms),
        .tdi_o       (tdi),
        .tdo_i       (tdo)
    );

    always #5 clk = ~clk;

    // Target model: one-bit TDI->TDO register clocked on TCK rise, or TDO tied high.
    always @(posedge tck) loop_q <= tdi;
    assign tdo = tdo_tied ? 1'b1 : loop_q;

    always @(posedge tck) begin
        tms_log.push_back(tms);
        tdi_log.push_back(tdi);
    end

    always @(negedge clk) if (rsp_valid) rsp_pulses++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MAX_LEN-1:0] exp_rsp(input logic [MAX_LEN-1:0] d, input int l, input bit tied);
        logic [MAX_LEN-1:0] r;
        r = '0;
        for (int i = 0; i < l; i++) begin
            if (tied) r[i] = 1'b1;
            else if (i > 0) r[i] = d[i-1];
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_tms(input int l, input bit ir);
        logic [63:0] v;
        int k;
        v = '0;
        k = 0;
        v[k] = 1'b1; k++;
        if (ir) begin v[k] = 1'b1; k++; end
        k += 2;
        for (int i = 0; i < l; i++) begin v[k] = (i == l - 1); k++; end
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] exp_tdi(input logic [MAX_LEN-1:0] d, input int l, input bit ir);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < l; i++) v[3 + int'(ir) + i] = d[i];
        return v;
    endfunction

    function automatic logic [63:0] pack_log(input bit sel_tdi, input int start);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 64; i++)
            if (start + i < tms_log.size()) v[i] = sel_tdi ? tdi_log[start + i] : tms_log[start + i];
        return v;
    endfunction

    task automatic wait_ready(input string tag);
        int c;
        c = 0;
        while (!cmd_ready && c < 4000) begin @(negedge clk); c++; end
        check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    task automatic wait_rsp(input string tag, input bit scramble, output int lat);
        logic [MAX_LEN-1:0] e;
        lat = 0;
        for (int c = 1; c <= 4000; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin lat = c; break; end
            if (scramble) cmd_data = MAX_LEN'({$urandom, $urandom});
        end
        check({tag, "_rsp_seen"}, 64'(lat != 0), 64'd1);
        if (lat != 0) begin
            check({tag, "_sb_depth"}, 64'(exp_q.size()), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({tag, "_rsp_data"}, 64'(rsp_data), 64'(e));
            end
            check({tag, "_busy_at_rsp"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic reset_and_init(input string tag);
        int start;
        int n;
        rst = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_rst_tck"}, 64'(tck), 64'd0);
        check({tag, "_rst_tms"}, 64'(tms), 64'd1);
        check({tag, "_rst_tdi"}, 64'(tdi), 64'd0);
        check({tag, "_rst_ready"}, 64'(cmd_ready), 64'd0);
        check({tag, "_rst_rspv"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rst_rspd"}, 64'(rsp_data), 64'd0);
        check({tag, "_rst_busy"}, 64'(busy), 64'd0);
        start = tms_log.size();
        rst = 1'b0;
        n = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (cmd_ready) begin n = c; break; end
        end
        check({tag, "_init_cycles"}, 64'(n), 64'd24);
        check({tag, "_init_periods"}, 64'(tms_log.size() - start), 64'd6);
        check({tag, "_init_tms"}, pack_log(1'b0, start), 64'h1F);
    endtask

    task automatic run_scan(input string tag, input bit ir, input int len_in,
                            input logic [MAX_LEN-1:0] d, input bit tied);
        int l;
        int start;
        int lat;
        int p0;
        logic [MAX_LEN-1:0] held;
        l = (len_in > int'(MAX_LEN)) ? int'(MAX_LEN) : len_in;
        tdo_tied = tied;
`ifdef JTAG_SCAN_MASTER_RTI_WAIT_EN
        rti_wait = 8'(rti_w);
`endif
        wait_ready(tag);
        cmd_valid = 1'b1;
        cmd_is_ir = ir;
        cmd_len   = LEN_W'(len_in);
        cmd_data  = d;
        exp_q.push_back(exp_rsp(d, l, tied));
        start = tms_log.size();
        p0 = rsp_pulses;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_rsp(tag, 1'b0, lat);
        held = rsp_data;
        if (l == 0) check({tag, "_latency"}, 64'(lat), 64'd2);
        @(posedge clk); #1;
        check({tag, "_pulse_len"}, 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, "_ready_after"}, 64'(cmd_ready), 64'd1);
        check({tag, "_rsp_hold"}, 64'(rsp_data), 64'(held));
        check({tag, "_pulses"}, 64'(rsp_pulses - p0), 64'd1);
        check({tag, "_periods"}, 64'(tms_log.size() - start),
              64'((l == 0) ? 0 : l + 5 + int'(ir) + rti_w));
        if (l > 0) begin
            check({tag, "_tms"}, pack_log(1'b0, start), exp_tms(l, ir));
            check({tag, "_tdi"}, pack_log(1'b1, start), exp_tdi(d, l, ir));
        end
    endtask

    task automatic busy_hold();
        logic [MAX_LEN-1:0] d1;
        logic [MAX_LEN-1:0] d2;
        int lat;
        d1 = MAX_LEN'({$urandom, $urandom});
        d2 = MAX_LEN'({$urandom, $urandom});
        tdo_tied = 1'b0;
        wait_ready("hold");
        cmd_valid = 1'b1;
        cmd_is_ir = 1'b0;
        cmd_len   = LEN_W'(8);
        cmd_data  = d1;
        exp_q.push_back(exp_rsp(d1, 8, 1'b0));
        @(posedge clk); #1;
        check("hold_busy", 64'(busy), 64'd1);
        wait_rsp("hold1", 1'b1, lat);
        cmd_data = d2;
        exp_q.push_back(exp_rsp(d2, 8, 1'b0));
        @(posedge clk); #1;
        check("hold_ready_up", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        check("hold_accept2", 64'(busy), 64'd1);
        cmd_valid = 1'b0;
        wait_rsp("hold2", 1'b0, lat);
    endtask

    task automatic mid_reset();
        int start;
        int c;
        int p0;
        tdo_tied = 1'b0;
        wait_ready("mrst");
        cmd_valid = 1'b1;
        cmd_is_ir = 1'b0;
        cmd_len   = LEN_W'(38);
        cmd_data  = MAX_LEN'({$urandom, $urandom});
        start = tms_log.size();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        c = 0;
        while (tms_log.size() - start < 13 && c < 2000) begin @(posedge clk); #1; c++; end
        check("mrst_reach_bit10", 64'(tms_log.size() - start), 64'd13);
        @(negedge clk);
        p0 = rsp_pulses;
        rst = 1'b1;
        #1;
        check("mrst_tck", 64'(tck), 64'd0);
        check("mrst_tms", 64'(tms), 64'd1);
        check("mrst_busy", 64'(busy), 64'd0);
        reset_and_init("mrst");
        check("mrst_no_rsp", 64'(rsp_pulses - p0), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_is_ir = 1'b0;
        cmd_len   = '0;
        cmd_data  = '0;
        tdo_tied  = 1'b0;
        rti_w     = 0;
`ifdef JTAG_SCAN_MASTER_RTI_WAIT_EN
        rti_wait  = 8'd0;
`endif
        reset_and_init("por");
        run_scan("dr38", 1'b0, 38, 38'h2A_5555_AAAA, 1'b0);
        run_scan("ir2", 1'b1, 2, 38'h2, 1'b1);
        run_scan("len0", 1'b0, 0, MAX_LEN'({$urandom, $urandom}), 1'b0);
        run_scan("len50", 1'b0, 50, MAX_LEN'({$urandom, $urandom}), 1'b0);
        busy_hold();
        for (int i = 0; i < 4; i++)
            run_scan($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), int'($urandom_range(1, 38)),
                     MAX_LEN'({$urandom, $urandom}), 1'($urandom_range(0, 1)));
`ifdef JTAG_SCAN_MASTER_RTI_WAIT_EN
        rti_w = 3;
`endif
        run_scan("dr4wait", 1'b0, 4, 38'hB, 1'b0);
        rti_w = 0;
        mid_reset();
        run_scan("post_rst", 1'b1, 5, 38'h15, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks", checks);
        $fatal(1);
    end

endmodule

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
- Initiator end of the virtual-JTAG debug link. Generates TCK/TMS/TDI and samples TDO to run IR and DR scans against the debug-slave TAP.
- Used by the on-chip debug bring-up controller and as the bench driver for the debug slave.
- Accepts one scan command at a time. Returns captured TDO bits as a single-cycle response.

Parameters:
- CLK_DIV, 2, clk cycles per TCK half-period (≥1).
- MAX_LEN, 38, maximum scan length in bits; equals the debug DR width.
- LEN_W, 6, width of cmd_len; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  scan command present.
- cmd_ready  out  1  master idle in RTI and able to accept a command.
- cmd_is_ir  in  1  1 = IR scan, 0 = DR scan.
- cmd_len  in  LEN_W  number of bits to shift.
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first.
- rsp_valid  out  1  one-cycle pulse when the scan is complete.
- rsp_data  out  MAX_LEN  TDO bits captured, LSB = first bit out.
- busy  out  1  high from command accept until rsp_valid.
- tck  out  1  JTAG clock.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data to target.
- tdo  in  1  JTAG data from target.

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0, state=INIT.
- Clocking:
  - One TCK period = 2*CLK_DIV clk cycles: low phase first, then high phase.
  - tms and tdi change only on the clk edge that drives tck 1→0.
  - tdo is sampled on the clk edge that drives tck 0→1.
- INIT (from reset): 5 TCK periods with tms=1 (Test-Logic-Reset), then 1 period with tms=0 (enter RTI). Then enter IDLE with cmd_ready=1.
- IDLE: tck held 0, tms=0.
  - Handshake completes on cmd_valid&cmd_ready at a clk edge.
  - On that edge: latch cmd_is_ir, effective length, and cmd_data; set cmd_ready=0 and busy=1.
  - Next clk cycle: start the scan.
- TMS sequence per TCK rising edge:
  - DR scan: 1 (SelDR), 0 (Capture), 0 (Shift), then len shift edges, 1 (Update), 0 (RTI).
  - IR scan: 1 (SelDR), 1 (SelIR), 0 (Capture), 0 (Shift), then len shift edges, 1 (Update), 0 (RTI).
  - Shift edges: tms=0 on the first len-1 edges and tms=1 on the last (Shift→Exit1).
  - Total TCK periods: len+5 (DR) or len+6 (IR).
- Shift data:
  - Shift edge i (0-based) drives tdi=cmd_data[i] during the preceding low phase.
  - Sample tdo into rsp_data[i]. rsp_data bits ≥ len are 0.
- Completion:
  - After the final RTI edge and its low phase, pulse rsp_valid=1 for one clk.
  - In the same cycle busy→0. cmd_ready→1 on the next cycle.
  - rsp_data holds its value until the next accept.
  - There is no response backpressure.
- Length rules:
  - cmd_len=0: accept the command, generate no TCK activity, pulse rsp_valid 2 clk later with rsp_data=0.
  - cmd_len>MAX_LEN: clamp to MAX_LEN.
- cmd_valid while busy: ignored (cmd_ready=0). The command is held by the initiator.
- Reset asserted mid-scan: all outputs return to reset values immediately and the scan is abandoned. No rsp_valid is produced. INIT re-runs after deassertion.
- Bit counter width: LEN_W. Divider counter width: clog2(CLK_DIV)+1.

Optional Feature:
- Macro: JTAG_SCAN_MASTER_RTI_WAIT_EN.
- Defined:
  - Adds input rti_wait[7:0].
  - After each scan returns to RTI, hold tms=0 and toggle tck for rti_wait additional TCK periods before rsp_valid.
  - This provides RTI cycles for the slave's ready-test-idle handshake.
  - rti_wait=0 behaves as if the macro were not defined.
- Not defined: no port, no extra periods; timing as above.

Test Plan:
- Reset release, CLK_DIV=2: tck shows 6 periods with tms=1,1,1,1,1,0; cmd_ready rises 24 clk after reset deassertion.
- DR scan len=38, data=38'h2A_5555_AAAA, tdo looped to tdi through a 1-bit register clocked on tck rise: 43 TCK periods; rsp_data=data shifted left by 1 with bit0=0; rsp_valid is a single pulse.
- IR scan len=2, data=2'b10, tdo tied 1: TMS edges 1,1,0,0,0,1,1,0; tdi=0 then 1 on shift edges; rsp_data=38'h3.
- cmd_len=0 and cmd_len=50: first gives no tck edges and rsp_data=0; second shifts exactly 38 bits.
- cmd_valid held during busy with a changing cmd_data: only the first command executes, and the second is accepted on the cycle after rsp_valid.
- Reset asserted at shift bit 10: tck=0 and tms=1 the same cycle, no rsp_valid, INIT re-runs; with JTAG_SCAN_MASTER_RTI_WAIT_EN and rti_wait=3, a DR len=4 scan takes 12 TCK periods.
